// File: rtl/axi_resp_router.sv
// Steers R and B responses from NUM_S slaves back to NUM_M masters along a route latched at AR/AW handshake.
// Latency: zero-cycle combinational forwarding once a route is live; route becomes live the cycle after the fire.
// Backpressure: slave READY mirrors the routed master READY; rd_accept/wr_accept drop while a response is in flight.
module axi_resp_router #(
    parameter int NUM_M  = 2,
    parameter int NUM_S  = 6,
    parameter int ID_W   = 4,
    parameter int IDS_W  = 8,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 4,
    localparam int MW    = (NUM_M > 1) ? $clog2(NUM_M) : 1,
    localparam int SW    = (NUM_S > 1) ? $clog2(NUM_S) : 1
) (
    input  logic                    ACLK,
    input  logic                    ARESETn,
    input  logic                    ar_fire,
    input  logic [MW-1:0]           ar_msel,
    input  logic [SW-1:0]           ar_ssel,
    input  logic [LEN_W-1:0]        ar_len,
    input  logic                    aw_fire,
    input  logic [MW-1:0]           aw_msel,
    input  logic [SW-1:0]           aw_ssel,
    input  logic [NUM_S*IDS_W-1:0]  RID_S,
    input  logic [NUM_S*DATA_W-1:0] RDATA_S,
    input  logic [NUM_S*2-1:0]      RRESP_S,
    input  logic [NUM_S-1:0]        RLAST_S,
    input  logic [NUM_S-1:0]        RVALID_S,
    output logic [NUM_S-1:0]        RREADY_S,
    output logic [NUM_M*ID_W-1:0]   RID_M,
    output logic [NUM_M*DATA_W-1:0] RDATA_M,
    output logic [NUM_M*2-1:0]      RRESP_M,
    output logic [NUM_M-1:0]        RLAST_M,
    output logic [NUM_M-1:0]        RVALID_M,
    input  logic [NUM_M-1:0]        RREADY_M,
    input  logic [NUM_S*IDS_W-1:0]  BID_S,
    input  logic [NUM_S*2-1:0]      BRESP_S,
    input  logic [NUM_S-1:0]        BVALID_S,
    output logic [NUM_S-1:0]        BREADY_S,
    output logic [NUM_M*ID_W-1:0]   BID_M,
    output logic [NUM_M*2-1:0]      BRESP_M,
    output logic [NUM_M-1:0]        BVALID_M,
    input  logic [NUM_M-1:0]        BREADY_M,
    output logic                    rd_accept,
    output logic                    wr_accept,
    output logic                    rlast_err,
    output logic                    route_err
);

    typedef enum logic {R_IDLE, R_DATA} rstate_t;
    typedef enum logic {W_IDLE, W_RESP} wstate_t;

    rstate_t           r_rstate, w_rstate_nxt;
    logic [MW-1:0]     r_rmsel, w_rmsel_nxt;
    logic [SW-1:0]     r_rssel, w_rssel_nxt;
    logic [LEN_W-1:0]  r_rlen, w_rlen_nxt;
    logic [LEN_W-1:0]  r_rcnt, w_rcnt_nxt;

    wstate_t           r_wstate, w_wstate_nxt;
    logic [MW-1:0]     r_wmsel, w_wmsel_nxt;
    logic [SW-1:0]     r_wssel, w_wssel_nxt;

    logic w_ar_idx_ok, w_aw_idx_ok;
    logic w_ar_take, w_aw_take;
    logic w_rbeat, w_rlast_cnt, w_rfinal;
    logic w_bhs;

    assign w_ar_idx_ok = (32'(ar_msel) < NUM_M) && (32'(ar_ssel) < NUM_S);
    assign w_aw_idx_ok = (32'(aw_msel) < NUM_M) && (32'(aw_ssel) < NUM_S);

    // Handshakes are seen directly on the routed pair; latched selects are always in range.
    assign w_rbeat     = (r_rstate == R_DATA) && RVALID_S[r_rssel] && RREADY_M[r_rmsel];
    assign w_rlast_cnt = (r_rcnt == r_rlen);
    assign w_rfinal    = w_rbeat && w_rlast_cnt;
    assign w_bhs       = (r_wstate == W_RESP) && BVALID_S[r_wssel] && BREADY_M[r_wmsel];

    assign rd_accept = (r_rstate == R_IDLE) || w_rfinal;
    assign wr_accept = (r_wstate == W_IDLE) || w_bhs;

    assign w_ar_take = ar_fire && rd_accept && w_ar_idx_ok;
    assign w_aw_take = aw_fire && wr_accept && w_aw_idx_ok;

    assign route_err = (ar_fire && !(rd_accept && w_ar_idx_ok)) ||
                       (aw_fire && !(wr_accept && w_aw_idx_ok));

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_rstate <= R_IDLE;
            r_rmsel  <= '0;
            r_rssel  <= '0;
            r_rlen   <= '0;
            r_rcnt   <= '0;
            r_wstate <= W_IDLE;
            r_wmsel  <= '0;
            r_wssel  <= '0;
        end else begin
            r_rstate <= w_rstate_nxt;
            r_rmsel  <= w_rmsel_nxt;
            r_rssel  <= w_rssel_nxt;
            r_rlen   <= w_rlen_nxt;
            r_rcnt   <= w_rcnt_nxt;
            r_wstate <= w_wstate_nxt;
            r_wmsel  <= w_wmsel_nxt;
            r_wssel  <= w_wssel_nxt;
        end
    end

    // A new request on the final-beat cycle overrides the return to idle, giving back-to-back bursts.
    always_comb begin
        w_rstate_nxt = r_rstate;
        w_rmsel_nxt  = r_rmsel;
        w_rssel_nxt  = r_rssel;
        w_rlen_nxt   = r_rlen;
        w_rcnt_nxt   = r_rcnt;
        if (w_rbeat) begin
            w_rcnt_nxt = r_rcnt + 1'b1;
        end
        if (w_rfinal) begin
            w_rstate_nxt = R_IDLE;
        end
        if (w_ar_take) begin
            w_rstate_nxt = R_DATA;
            w_rmsel_nxt  = ar_msel;
            w_rssel_nxt  = ar_ssel;
            w_rlen_nxt   = ar_len;
            w_rcnt_nxt   = '0;
        end
    end

    always_comb begin
        w_wstate_nxt = r_wstate;
        w_wmsel_nxt  = r_wmsel;
        w_wssel_nxt  = r_wssel;
        if (w_bhs) begin
            w_wstate_nxt = W_IDLE;
        end
        if (w_aw_take) begin
            w_wstate_nxt = W_RESP;
            w_wmsel_nxt  = aw_msel;
            w_wssel_nxt  = aw_ssel;
        end
    end

    // RLAST toward the master comes from the beat count; slave RLAST only feeds the error check.
    always_comb begin
        RVALID_M  = '0;
        RREADY_S  = '0;
        RID_M     = '0;
        RDATA_M   = '0;
        RRESP_M   = '0;
        RLAST_M   = '0;
        rlast_err = 1'b0;
        if (r_rstate == R_DATA) begin
            RVALID_M[r_rmsel]                    = RVALID_S[r_rssel];
            RREADY_S[r_rssel]                    = RREADY_M[r_rmsel];
            RID_M[r_rmsel*ID_W +: ID_W]          = RID_S[r_rssel*IDS_W +: ID_W];
            RDATA_M[r_rmsel*DATA_W +: DATA_W]    = RDATA_S[r_rssel*DATA_W +: DATA_W];
            RRESP_M[r_rmsel*2 +: 2]              = RRESP_S[r_rssel*2 +: 2];
            RLAST_M[r_rmsel]                     = w_rlast_cnt;
            rlast_err = w_rbeat && (RLAST_S[r_rssel] != w_rlast_cnt);
        end
    end

    always_comb begin
        BVALID_M = '0;
        BREADY_S = '0;
        BID_M    = '0;
        BRESP_M  = '0;
        if (r_wstate == W_RESP) begin
            BVALID_M[r_wmsel]           = BVALID_S[r_wssel];
            BREADY_S[r_wssel]           = BREADY_M[r_wmsel];
            BID_M[r_wmsel*ID_W +: ID_W] = BID_S[r_wssel*IDS_W +: ID_W];
            BRESP_M[r_wmsel*2 +: 2]     = BRESP_S[r_wssel*2 +: 2];
        end
    end

endmodule

// File: tb/tb_axi_resp_router.sv
// Directed bench for axi_resp_router: routing, RLAST regeneration, back-to-back reads, stalls, B path, reset.
module tb_axi_resp_router;

    logic        ACLK = 1'b0;
    logic        ARESETn;
    logic        ar_fire;
    logic [0:0]  ar_msel;
    logic [2:0]  ar_ssel;
    logic [3:0]  ar_len;
    logic        aw_fire;
    logic [0:0]  aw_msel;
    logic [2:0]  aw_ssel;
    logic [47:0] RID_S;
    logic [191:0] RDATA_S;
    logic [11:0] RRESP_S;
    logic [5:0]  RLAST_S;
    logic [5:0]  RVALID_S;
    logic [5:0]  RREADY_S;
    logic [7:0]  RID_M;
    logic [63:0] RDATA_M;
    logic [3:0]  RRESP_M;
    logic [1:0]  RLAST_M;
    logic [1:0]  RVALID_M;
    logic [1:0]  RREADY_M;
    logic [47:0] BID_S;
    logic [11:0] BRESP_S;
    logic [5:0]  BVALID_S;
    logic [5:0]  BREADY_S;
    logic [7:0]  BID_M;
    logic [3:0]  BRESP_M;
    logic [1:0]  BVALID_M;
    logic [1:0]  BREADY_M;
    logic        rd_accept;
    logic        wr_accept;
    logic        rlast_err;
    logic        route_err;

    int checks = 0;
    int failures = 0;

    axi_resp_router dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .ar_fire(ar_fire), .ar_msel(ar_msel), .ar_ssel(ar_ssel), .ar_len(ar_len),
        .aw_fire(aw_fire), .aw_msel(aw_msel), .aw_ssel(aw_ssel),
        .RID_S(RID_S), .RDATA_S(RDATA_S), .RRESP_S(RRESP_S), .RLAST_S(RLAST_S),
        .RVALID_S(RVALID_S), .RREADY_S(RREADY_S),
        .RID_M(RID_M), .RDATA_M(RDATA_M), .RRESP_M(RRESP_M), .RLAST_M(RLAST_M),
        .RVALID_M(RVALID_M), .RREADY_M(RREADY_M),
        .BID_S(BID_S), .BRESP_S(BRESP_S), .BVALID_S(BVALID_S), .BREADY_S(BREADY_S),
        .BID_M(BID_M), .BRESP_M(BRESP_M), .BVALID_M(BVALID_M), .BREADY_M(BREADY_M),
        .rd_accept(rd_accept), .wr_accept(wr_accept),
        .rlast_err(rlast_err), .route_err(route_err)
    );

    always #5 ACLK = ~ACLK;

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic clear_inputs();
        ar_fire = 0; ar_msel = '0; ar_ssel = '0; ar_len = '0;
        aw_fire = 0; aw_msel = '0; aw_ssel = '0;
        RID_S = '0; RDATA_S = '0; RRESP_S = '0; RLAST_S = '0; RVALID_S = '0;
        RREADY_M = '0; BID_S = '0; BRESP_S = '0; BVALID_S = '0; BREADY_M = '0;
    endtask

    task automatic set_r(input int s, input logic [7:0] id, input logic [31:0] d,
                         input logic [1:0] rs, input logic last);
        RID_S[s*8 +: 8]    = id;
        RDATA_S[s*32 +: 32] = d;
        RRESP_S[s*2 +: 2]  = rs;
        RLAST_S[s]         = last;
        RVALID_S[s]        = 1'b1;
    endtask

    task automatic issue_ar(input logic [0:0] m, input logic [2:0] s, input logic [3:0] len);
        ar_fire = 1; ar_msel = m; ar_ssel = s; ar_len = len;
        tick();
        ar_fire = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        ARESETn = 0;
        #3;
        checks++; if (rd_accept !== 1'b1 || wr_accept !== 1'b1) begin failures++; $display("FAIL reset_accept got=%b%b exp=11", rd_accept, wr_accept); end
        checks++; if ({RVALID_M, RLAST_M, BVALID_M, RREADY_S, BREADY_S, rlast_err, route_err} !== 18'h0) begin failures++; $display("FAIL reset_ctrl got=%h exp=0", {RVALID_M, RLAST_M, BVALID_M, RREADY_S, BREADY_S, rlast_err, route_err}); end
        checks++; if ({RDATA_M, RID_M, RRESP_M, BID_M, BRESP_M} !== 88'h0) begin failures++; $display("FAIL reset_data got=%h exp=0", {RDATA_M, RID_M, RRESP_M, BID_M, BRESP_M}); end
        ARESETn = 1;
        tick();
    endtask

    task automatic test_basic_read();
        ar_fire = 1; ar_msel = 0; ar_ssel = 2; ar_len = 3;
        #2;
        checks++; if (rd_accept !== 1'b1 || route_err !== 1'b0) begin failures++; $display("FAIL t1_fire acc=%b err=%b exp=1,0", rd_accept, route_err); end
        tick();
        ar_fire = 0;
        RREADY_M = 2'b01;
        for (int i = 0; i < 4; i++) begin
            set_r(2, 8'h5C, 32'hA000_0000 + i, 2'b01, (i == 3));
            #2;
            checks++; if (RVALID_M !== 2'b01 || RREADY_S !== 6'b000100) begin failures++; $display("FAIL t1_vld beat%0d vm=%b rs=%b exp=01,000100", i, RVALID_M, RREADY_S); end
            checks++; if (RDATA_M[31:0] !== 32'hA000_0000 + i || RID_M[3:0] !== 4'hC || RRESP_M[1:0] !== 2'b01) begin failures++; $display("FAIL t1_data beat%0d d=%h id=%h r=%b", i, RDATA_M[31:0], RID_M[3:0], RRESP_M[1:0]); end
            checks++; if (RLAST_M !== {1'b0, (i == 3)} || rlast_err !== 1'b0) begin failures++; $display("FAIL t1_last beat%0d last=%b err=%b exp=%b,0", i, RLAST_M, rlast_err, (i == 3)); end
            tick();
        end
        clear_inputs();
        #2;
        checks++; if (rd_accept !== 1'b1 || RVALID_M !== 2'b00) begin failures++; $display("FAIL t1_end acc=%b vm=%b exp=1,00", rd_accept, RVALID_M); end
        tick();
    endtask

    task automatic test_rlast_err();
        logic exp_err;
        issue_ar(1, 1, 3);
        RREADY_M = 2'b10;
        for (int i = 0; i < 4; i++) begin
            set_r(1, 8'h03, 32'hB100_0000 + i, 2'b00, (i == 1));
            exp_err = (i == 1) != (i == 3);
            #2;
            checks++; if (RLAST_M !== {(i == 3), 1'b0}) begin failures++; $display("FAIL t2_last beat%0d got=%b", i, RLAST_M); end
            checks++; if (rlast_err !== exp_err) begin failures++; $display("FAIL t2_err beat%0d got=%b exp=%b", i, rlast_err, exp_err); end
            checks++; if (rd_accept !== (i == 3)) begin failures++; $display("FAIL t2_acc beat%0d got=%b exp=%b", i, rd_accept, (i == 3)); end
            tick();
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_back_to_back();
        issue_ar(1, 0, 1);
        RREADY_M = 2'b10;
        set_r(0, 8'h11, 32'hC000_0000, 2'b00, 0);
        #2;
        checks++; if (RVALID_M !== 2'b10 || rd_accept !== 1'b0) begin failures++; $display("FAIL t3_b0 vm=%b acc=%b", RVALID_M, rd_accept); end
        tick();
        set_r(0, 8'h11, 32'hC000_0001, 2'b00, 1);
        ar_fire = 1; ar_msel = 0; ar_ssel = 5; ar_len = 0;
        #2;
        checks++; if (rd_accept !== 1'b1 || route_err !== 1'b0 || RLAST_M !== 2'b10) begin failures++; $display("FAIL t3_b1 acc=%b err=%b last=%b", rd_accept, route_err, RLAST_M); end
        tick();
        clear_inputs();
        RREADY_M = 2'b01;
        set_r(5, 8'hE9, 32'hD00D_0005, 2'b11, 1);
        #2;
        checks++; if (RVALID_M !== 2'b01 || RREADY_S !== 6'b100000 || RLAST_M !== 2'b01) begin failures++; $display("FAIL t3_new vm=%b rs=%b last=%b", RVALID_M, RREADY_S, RLAST_M); end
        checks++; if (RDATA_M[31:0] !== 32'hD00D_0005 || RID_M[3:0] !== 4'h9 || rlast_err !== 1'b0) begin failures++; $display("FAIL t3_dat d=%h id=%h err=%b", RDATA_M[31:0], RID_M[3:0], rlast_err); end
        tick();
        RREADY_M = 2'b00;
        #2;
        checks++; if (rd_accept !== 1'b1 || RVALID_M !== 2'b00) begin failures++; $display("FAIL t3_idle acc=%b vm=%b", rd_accept, RVALID_M); end
        clear_inputs();
        tick();
    endtask

    task automatic test_stall();
        issue_ar(0, 3, 3);
        RREADY_M = 2'b01;
        for (int i = 0; i < 2; i++) begin
            set_r(3, 8'h02, 32'hE000_0000 + i, 2'b00, 0);
            tick();
        end
        set_r(3, 8'h02, 32'hE000_0002, 2'b00, 0);
        RREADY_M = 2'b00;
        for (int c = 0; c < 5; c++) begin
            ar_fire = (c == 2); ar_msel = 1; ar_ssel = 0; ar_len = 0;
            #2;
            checks++; if (RREADY_S !== 6'b0 || RVALID_M !== 2'b01 || RDATA_M[31:0] !== 32'hE000_0002 || RLAST_M !== 2'b00) begin failures++; $display("FAIL t4_stall c%0d rs=%b vm=%b d=%h last=%b", c, RREADY_S, RVALID_M, RDATA_M[31:0], RLAST_M); end
            checks++; if (route_err !== (c == 2) || rd_accept !== 1'b0) begin failures++; $display("FAIL t4_rerr c%0d err=%b acc=%b exp=%b,0", c, route_err, rd_accept, (c == 2)); end
            tick();
        end
        ar_fire = 0;
        RREADY_M = 2'b01;
        for (int i = 2; i < 4; i++) begin
            set_r(3, 8'h02, 32'hE000_0000 + i, 2'b00, (i == 3));
            #2;
            checks++; if (RVALID_M !== 2'b01 || RREADY_S !== 6'b001000 || RLAST_M !== {1'b0, (i == 3)}) begin failures++; $display("FAIL t4_resume beat%0d vm=%b rs=%b last=%b", i, RVALID_M, RREADY_S, RLAST_M); end
            tick();
        end
        clear_inputs();
        #2;
        checks++; if (rd_accept !== 1'b1) begin failures++; $display("FAIL t4_end acc=%b exp=1", rd_accept); end
        tick();
    endtask

    task automatic test_read_write();
        ar_fire = 1; ar_msel = 0; ar_ssel = 3; ar_len = 0;
        aw_fire = 1; aw_msel = 1; aw_ssel = 4;
        #2;
        checks++; if (rd_accept !== 1'b1 || wr_accept !== 1'b1 || route_err !== 1'b0) begin failures++; $display("FAIL t5_fire ra=%b wa=%b err=%b", rd_accept, wr_accept, route_err); end
        tick();
        ar_fire = 0; aw_fire = 0;
        BVALID_S[4] = 1; BID_S[4*8 +: 8] = 8'hA7; BRESP_S[4*2 +: 2] = 2'b10;
        set_r(3, 8'h31, 32'h3333_0000, 2'b00, 1);
        #2;
        checks++; if (BVALID_M !== 2'b10 || BREADY_S !== 6'b0 || wr_accept !== 1'b0) begin failures++; $display("FAIL t5_bwait bv=%b brs=%b wa=%b", BVALID_M, BREADY_S, wr_accept); end
        tick();
        BREADY_M = 2'b10; RREADY_M = 2'b01;
        #2;
        checks++; if (BREADY_S !== 6'b010000 || BID_M !== 8'h70 || BRESP_M !== 4'b1000 || wr_accept !== 1'b1) begin failures++; $display("FAIL t5_b brs=%b id=%h r=%b wa=%b", BREADY_S, BID_M, BRESP_M, wr_accept); end
        checks++; if (RVALID_M !== 2'b01 || RREADY_S !== 6'b001000 || RID_M !== 8'h01 || RLAST_M !== 2'b01) begin failures++; $display("FAIL t5_r vm=%b rs=%b id=%h last=%b", RVALID_M, RREADY_S, RID_M, RLAST_M); end
        tick();
        clear_inputs();
        #2;
        checks++; if (wr_accept !== 1'b1 || rd_accept !== 1'b1 || BVALID_M !== 2'b00) begin failures++; $display("FAIL t5_end wa=%b ra=%b bv=%b", wr_accept, rd_accept, BVALID_M); end
        tick();
    endtask

    task automatic test_reset_mid_and_bad_index();
        issue_ar(0, 2, 7);
        RREADY_M = 2'b01;
        set_r(2, 8'h22, 32'hF000_0000, 2'b00, 0);
        tick();
        set_r(2, 8'h22, 32'hF000_0001, 2'b00, 0);
        #1;
        ARESETn = 0;
        #1;
        checks++; if ({RVALID_M, RLAST_M, RREADY_S, RDATA_M, RID_M, rlast_err} !== 87'h0 || rd_accept !== 1'b1 || wr_accept !== 1'b1) begin failures++; $display("FAIL t6_rst vm=%b rs=%b d=%h ra=%b wa=%b", RVALID_M, RREADY_S, RDATA_M, rd_accept, wr_accept); end
        #1;
        ARESETn = 1;
        tick();
        checks++; if (RVALID_M !== 2'b00 || RREADY_S !== 6'b0 || rd_accept !== 1'b1) begin failures++; $display("FAIL t6_after vm=%b rs=%b ra=%b", RVALID_M, RREADY_S, rd_accept); end
        clear_inputs();
        issue_ar(1, 2, 0);
        RREADY_M = 2'b10;
        set_r(2, 8'h4B, 32'h1234_5678, 2'b00, 1);
        #2;
        checks++; if (RVALID_M !== 2'b10 || RLAST_M !== 2'b10 || RDATA_M[63:32] !== 32'h1234_5678 || RID_M[7:4] !== 4'hB) begin failures++; $display("FAIL t6_len0 vm=%b last=%b d=%h id=%h", RVALID_M, RLAST_M, RDATA_M[63:32], RID_M[7:4]); end
        tick();
        clear_inputs();
        RVALID_S = 6'b111111; RREADY_M = 2'b11;
        ar_fire = 1; ar_msel = 0; ar_ssel = 6; ar_len = 0;
        #2;
        checks++; if (route_err !== 1'b1) begin failures++; $display("FAIL t6_bad_err got=%b exp=1", route_err); end
        tick();
        ar_fire = 0;
        #2;
        checks++; if (RVALID_M !== 2'b00 || RREADY_S !== 6'b0 || rd_accept !== 1'b1 || route_err !== 1'b0) begin failures++; $display("FAIL t6_bad_idle vm=%b rs=%b ra=%b err=%b", RVALID_M, RREADY_S, rd_accept, route_err); end
        aw_fire = 1; aw_msel = 1; aw_ssel = 7;
        #1;
        checks++; if (route_err !== 1'b1) begin failures++; $display("FAIL t6_bad_aw got=%b exp=1", route_err); end
        tick();
        aw_fire = 0;
        BVALID_S = 6'b111111; BREADY_M = 2'b11;
        #2;
        checks++; if (BVALID_M !== 2'b00 || BREADY_S !== 6'b0 || wr_accept !== 1'b1) begin failures++; $display("FAIL t6_bad_widle bv=%b brs=%b wa=%b", BVALID_M, BREADY_S, wr_accept); end
        clear_inputs();
        tick();
    endtask

    initial begin
        test_reset();
        test_basic_read();
        test_rlast_err();
        test_back_to_back();
        test_stall();
        test_read_write();
        test_reset_mid_and_bad_index();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
